// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the memory controller: FSM encoding, I/O window and
// transfer-size limits.
package mem_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    FETCH   = 3'd1,
    LOAD    = 3'd2,
    STORE   = 3'd3,
    IO_WAIT = 3'd4
  } state_e;

  localparam logic [1:0] IO_ADDR_HI = 2'b11;
  localparam int         MAX_BYTES  = 4;

  // Only 1/2/4-byte transfers exist; anything else is widened to a full word.
  function automatic logic [2:0] size_dec(input logic [2:0] s);
    return (s == 3'd1 || s == 3'd2) ? s : 3'(MAX_BYTES);
  endfunction

endpackage

// File: rtl/mem_ctrl_if.sv
// Signal bundle between the memory controller and its clients (fetcher, LSB,
// ROB) plus the byte-wide RAM port.
interface mem_ctrl_if;
  logic        rdy_in;
  logic        io_buffer_full;
  logic [7:0]  mem_din;
  logic [7:0]  mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic        en_signal_from_fetcher;
  logic [31:0] pc_from_fetcher;
  logic        drop_flag_from_fetcher;
  logic [31:0] inst_to_fetcher;
  logic        ok_flag_to_fetcher;
  logic        en_signal_from_lsb;
  logic        wr_flag_from_lsb;
  logic [31:0] addr_from_lsb;
  logic [2:0]  size_from_lsb;
  logic [31:0] data_from_lsb;
  logic [31:0] data_to_lsb;
  logic        ok_flag_to_lsb;
  logic        rollback_flag_from_rob;

  modport master (
    input  rdy_in, io_buffer_full, mem_din,
    input  en_signal_from_fetcher, pc_from_fetcher, drop_flag_from_fetcher,
    input  en_signal_from_lsb, wr_flag_from_lsb, addr_from_lsb, size_from_lsb,
    input  data_from_lsb, rollback_flag_from_rob,
    output mem_dout, mem_a, mem_wr, inst_to_fetcher, ok_flag_to_fetcher,
    output data_to_lsb, ok_flag_to_lsb
  );

  modport slave (
    output rdy_in, io_buffer_full, mem_din,
    output en_signal_from_fetcher, pc_from_fetcher, drop_flag_from_fetcher,
    output en_signal_from_lsb, wr_flag_from_lsb, addr_from_lsb, size_from_lsb,
    output data_from_lsb, rollback_flag_from_rob,
    input  mem_dout, mem_a, mem_wr, inst_to_fetcher, ok_flag_to_fetcher,
    input  data_to_lsb, ok_flag_to_lsb
  );
endinterface

// File: rtl/mem_ctrl.sv
// Byte-serial memory controller arbitrating instruction fetch and LSB traffic.
// The RAM read port has one edge of latency and stalls with rdy_in like the core.
module mem_ctrl
  import mem_ctrl_pkg::*;
(
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        io_buffer_full,
  input  logic [7:0]  mem_din,
  output logic [7:0]  mem_dout,
  output logic [31:0] mem_a,
  output logic        mem_wr,
  input  logic        en_signal_from_fetcher,
  input  logic [31:0] pc_from_fetcher,
  input  logic        drop_flag_from_fetcher,
  output logic [31:0] inst_to_fetcher,
  output logic        ok_flag_to_fetcher,
  input  logic        en_signal_from_lsb,
  input  logic        wr_flag_from_lsb,
  input  logic [31:0] addr_from_lsb,
  input  logic [2:0]  size_from_lsb,
  input  logic [31:0] data_from_lsb,
  output logic [31:0] data_to_lsb,
  output logic        ok_flag_to_lsb,
  input  logic        rollback_flag_from_rob
);

  state_e      state_q, state_d;
  logic [2:0]  cnt_q, len_q;
  logic        f_vld_q, l_vld_q, l_wr_q, mem_wr_q;
  logic [31:0] f_pc_q, l_addr_q, l_data_q, acc_q, st_q;
  logic [2:0]  l_size_q;

  // Effective request: a pulse this cycle overrides the held slot, so a
  // request can be started from IDLE on the edge that samples it.
  logic        kill_f, l_squash, f_req, l_req, l_wr, l_io;
  logic [31:0] f_pc, l_addr, l_data;
  logic [2:0]  l_len;

  assign kill_f   = drop_flag_from_fetcher | rollback_flag_from_rob;
  assign l_squash = rollback_flag_from_rob & ~l_wr_q;
  assign f_req    = en_signal_from_fetcher | (f_vld_q & ~kill_f);
  assign l_req    = en_signal_from_lsb | (l_vld_q & ~l_squash);
  assign f_pc     = en_signal_from_fetcher ? pc_from_fetcher : f_pc_q;
  assign l_wr     = en_signal_from_lsb ? wr_flag_from_lsb : l_wr_q;
  assign l_addr   = en_signal_from_lsb ? addr_from_lsb : l_addr_q;
  assign l_data   = en_signal_from_lsb ? data_from_lsb : l_data_q;
  assign l_len    = size_dec(en_signal_from_lsb ? size_from_lsb : l_size_q);
  assign l_io     = (l_addr[17:16] == IO_ADDR_HI);

  assign mem_wr   = mem_wr_q & rdy_in;

  logic rd_st, start_l, start_f, abort, rd_issue, rd_sample, rd_done;
  logic st_go, st_issue, st_done;

  // Read pipeline: at the edge where cnt == k, address base+k goes out
  // (k < len) and byte k-2 arrives (k >= 2); the last byte lands at k == len+1.
  always_comb begin
    rd_st     = (state_q == FETCH) || (state_q == LOAD);
    start_l   = (state_q == IDLE) && l_req;
    start_f   = (state_q == IDLE) && !l_req && f_req;
    abort     = ((state_q == FETCH) && kill_f) ||
                ((state_q == LOAD) && rollback_flag_from_rob);
    rd_issue  = rd_st && !abort && (cnt_q < len_q);
    rd_sample = rd_st && !abort && (cnt_q >= 3'd2);
    rd_done   = rd_st && !abort && (cnt_q == len_q + 3'd1);
    st_go     = ((state_q == IO_WAIT) && !io_buffer_full) ||
                (start_l && l_wr && !(l_io && io_buffer_full));
    st_issue  = (state_q == STORE) && (cnt_q < len_q);
    st_done   = (state_q == STORE) && (cnt_q == len_q);
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:        if (start_l)      state_d = !l_wr ? LOAD : (st_go ? STORE : IO_WAIT);
                   else if (start_f) state_d = FETCH;
      FETCH, LOAD: if (abort || rd_done) state_d = IDLE;
      STORE:       if (st_done) state_d = IDLE;
      IO_WAIT:     if (st_go) state_d = STORE;
      default:     state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in)     state_q <= IDLE;
    else if (rdy_in) state_q <= state_d;
  end

  // Bytes shift in from the top; the final right shift drops unfilled lanes
  // and zero-extends short loads.
  logic [31:0] rd_word;
  logic [4:0]  rd_sh;
  assign rd_word = {mem_din, acc_q[31:8]};
  assign rd_sh   = {2'(3'd4 - len_q), 3'b000};

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      cnt_q <= '0; len_q <= '0;
      f_vld_q <= 1'b0; f_pc_q <= '0;
      l_vld_q <= 1'b0; l_wr_q <= 1'b0; l_addr_q <= '0; l_size_q <= '0; l_data_q <= '0;
      acc_q <= '0; st_q <= '0;
      mem_a <= '0; mem_dout <= '0; mem_wr_q <= 1'b0;
      inst_to_fetcher <= '0; ok_flag_to_fetcher <= 1'b0;
      data_to_lsb <= '0; ok_flag_to_lsb <= 1'b0;
    end else if (rdy_in) begin
      ok_flag_to_fetcher <= 1'b0;
      ok_flag_to_lsb     <= 1'b0;
      mem_wr_q           <= 1'b0;

      // A fetch arriving with drop/rollback carries the redirected pc: keep it.
      if (start_f) f_vld_q <= 1'b0;
      else if (en_signal_from_fetcher) begin
        f_vld_q <= 1'b1;
        f_pc_q  <= pc_from_fetcher;
      end else if (kill_f) f_vld_q <= 1'b0;

      if (start_l) l_vld_q <= 1'b0;
      else if (en_signal_from_lsb) begin
        l_vld_q  <= 1'b1;
        l_wr_q   <= wr_flag_from_lsb;
        l_addr_q <= addr_from_lsb;
        l_size_q <= size_from_lsb;
        l_data_q <= data_from_lsb;
      end else if (l_squash) l_vld_q <= 1'b0;

      if (start_l || start_f) begin
        mem_a <= start_l ? l_addr : f_pc;
        len_q <= start_l ? l_len : 3'(MAX_BYTES);
        cnt_q <= 3'd1;
        acc_q <= '0;
        st_q  <= l_data;
      end

      if (rd_st)     cnt_q <= cnt_q + 3'd1;
      if (rd_issue)  mem_a <= mem_a + 32'd1;
      if (rd_sample) acc_q <= rd_word;
      if (rd_done) begin
        if (state_q == FETCH) begin
          inst_to_fetcher    <= rd_word >> rd_sh;
          ok_flag_to_fetcher <= 1'b1;
        end else begin
          data_to_lsb    <= rd_word >> rd_sh;
          ok_flag_to_lsb <= 1'b1;
        end
      end

      if (st_go) begin
        mem_wr_q <= 1'b1;
        mem_dout <= (state_q == IO_WAIT) ? st_q[7:0] : l_data[7:0];
        st_q     <= ((state_q == IO_WAIT) ? st_q : l_data) >> 8;
        cnt_q    <= 3'd1;
      end
      if (st_issue) begin
        mem_wr_q <= 1'b1;
        mem_a    <= mem_a + 32'd1;
        mem_dout <= st_q[7:0];
        st_q     <= st_q >> 8;
        cnt_q    <= cnt_q + 3'd1;
      end
      if (st_done) ok_flag_to_lsb <= 1'b1;
    end
  end

endmodule
